// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display blocks.
//   SEG_OFF      : active-low segment pattern with every segment dark
//   scan_state_e : per-digit scan phase (BLANK = anodes off, DRIVE = anode on)
//   hex_to_seg   : active-low {g,f,e,d,c,b,a} pattern for one hex nibble
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/Clock_Enable.sv
// Clock-enable generator: emits a one-cycle tick every src_freq/target_freq
// clk cycles (at least every cycle).
//   clk  : system clock
//   clr  : asynchronous reset, active-high
//   tick : one-cycle enable pulse, registered
module Clock_Enable #(
  parameter int src_freq    = 100000000,
  parameter int target_freq = 1000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int DIV_RAW = src_freq / target_freq;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // The tick is registered, so it appears the cycle after the counter
  // sits at its limit, while the counter itself wraps to zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LIMIT);
      if (cnt == LIMIT) cnt <= '0;
      else              cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Each digit spends BLANK_TICKS scan ticks dark (ghost suppression) and then
// DRIVE_TICKS ticks lit. New values arrive through load and are committed
// only at the frame boundary, acknowledged by a one-cycle load_ack.
//   clk, clr : clock, asynchronous active-high reset
//   value    : hex nibbles, digit 0 rightmost
//   dp_mask  : decimal point enable per digit (1 = lit)
//   lzb_en   : leading-zero blanking enable
//   load     : capture value/dp_mask/lzb_en into the pending slot
//   load_ack : pending value became active this frame
//   an       : anodes, active-low
//   seg      : {g,f,e,d,c,b,a}, active-low
//   dp       : decimal point, active-low
module seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int SRC_FREQ    = 100000000,
  parameter int SCAN_FREQ   = 1000,
  parameter int NUM_DIGITS  = 4,
  parameter int BLANK_TICKS = 1,
  parameter int DRIVE_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lzb_en,
  input  logic                    load,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int VW     = 4 * NUM_DIGITS;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PH_MAX = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [PH_W-1:0]  BLANK_LAST = PH_W'(BLANK_TICKS - 1);
  localparam logic [PH_W-1:0]  DRIVE_LAST = PH_W'(DRIVE_TICKS - 1);

  logic tick;

  Clock_Enable #(
    .src_freq    (SRC_FREQ),
    .target_freq (SCAN_FREQ)
  ) u_tick (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  scan_state_e      state, state_nxt;
  logic [DIG_W-1:0] digit, digit_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;
  logic             frame_end;

  logic [VW-1:0]         act_val, pend_val;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp;
  logic                  act_lzb, pend_lzb, pend_vld;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= BLANK;
      digit <= '0;
      phase <= '0;
    end else begin
      state <= state_nxt;
      digit <= digit_nxt;
      phase <= phase_nxt;
    end
  end

  // Only scan ticks advance the sequence; frame_end marks the
  // DRIVE(last digit) -> BLANK(digit 0) transition cycle.
  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    phase_nxt = phase;
    frame_end = 1'b0;
    if (tick) begin
      case (state)
        BLANK: begin
          if (phase == BLANK_LAST) begin
            state_nxt = DRIVE;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + PH_W'(1);
          end
        end
        DRIVE: begin
          if (phase == DRIVE_LAST) begin
            state_nxt = BLANK;
            phase_nxt = '0;
            if (digit == DIG_LAST) begin
              digit_nxt = '0;
              frame_end = 1'b1;
            end else begin
              digit_nxt = digit + DIG_W'(1);
            end
          end else begin
            phase_nxt = phase + PH_W'(1);
          end
        end
        default: begin
          state_nxt = BLANK;
          phase_nxt = '0;
        end
      endcase
    end
  end

  // Commit happens before the load capture so a load landing on the
  // boundary cycle stays pending for the next frame.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      act_val  <= '0;
      act_dp   <= '0;
      act_lzb  <= 1'b0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_lzb <= 1'b0;
      pend_vld <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= frame_end & pend_vld;
      if (frame_end && pend_vld) begin
        act_val  <= pend_val;
        act_dp   <= pend_dp;
        act_lzb  <= pend_lzb;
        pend_vld <= 1'b0;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_mask;
        pend_lzb <= lzb_en;
        pend_vld <= 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  hi_zero;

  always_comb begin
    lz_blank = '0;
    hi_zero  = act_lzb;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero     = hi_zero && (act_val[4*i +: 4] == 4'h0);
      lz_blank[i] = hi_zero;
    end
  end

  logic [NUM_DIGITS-1:0] an_p0;
  logic [6:0]            seg_p0;
  logic                  dp_p0;
  logic [3:0]            nib;

  always_comb begin
    an_p0  = '1;
    seg_p0 = SEG_OFF;
    dp_p0  = 1'b1;
    nib    = act_val[int'(digit)*4 +: 4];
    if (state == DRIVE) begin
      an_p0[digit] = 1'b0;
      seg_p0       = lz_blank[digit] ? SEG_OFF : hex_to_seg(nib);
      dp_p0        = ~act_dp[digit];
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a 10-cycle scan tick, 4 digits, 1 blank tick
// and 3 drive ticks per digit (16 ticks = 160 cycles per frame).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        lzb_en = 1'b0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .SRC_FREQ    (10),
    .SCAN_FREQ   (1),
    .NUM_DIGITS  (4),
    .BLANK_TICKS (1),
    .DRIVE_TICKS (3)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .value    (value),
    .dp_mask  (dp_mask),
    .lzb_en   (lzb_en),
    .load     (load),
    .load_ack (load_ack),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int tests = 0;
  int fails = 0;
  int p = -1;        // index of the most recent rising edge since reset release
  int ack_q[$];      // edges after which load_ack must be high

  logic [15:0] m_act_val, m_pend_val;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_act_lzb, m_pend_lzb, m_pv;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, p, act, exp);
    end
  endtask

  // Reference model: after edge p the outputs show the scan slot reached
  // after edge p-1. Ticks land on edges 10,20,...; slot n = edge/10, each
  // frame is 16 slots (4 digits x {1 blank, 3 drive}).
  always @(posedge clk) begin : model
    int n, pos, d, nib;
    logic blanked;
    #1;
    if (clr) begin
      p = -1;
      m_act_val = '0; m_act_dp = '0; m_act_lzb = 1'b0;
      m_pend_val = '0; m_pend_dp = '0; m_pend_lzb = 1'b0; m_pv = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      ack_q.delete();
    end else begin
      p++;
      n   = (p - 1) / 10;
      pos = n % 16;
      d   = pos / 4;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (pos % 4 != 0) begin
        e_an[d] = 1'b0;
        nib     = int'((m_act_val >> (4 * d)) & 16'hF);
        blanked = m_act_lzb && (d >= 1) && ((m_act_val >> (4 * d)) == 16'h0);
        e_seg   = blanked ? 7'h7F : SEG_TAB[nib];
        e_dp    = ~m_act_dp[d];
      end
      if (p > 0 && p % 160 == 0 && m_pv) begin
        m_act_val = m_pend_val; m_act_dp = m_pend_dp; m_act_lzb = m_pend_lzb;
        m_pv = 1'b0;
        ack_q.push_back(p);
      end
      if (load) begin
        m_pend_val = value; m_pend_dp = dp_mask; m_pend_lzb = lzb_en;
        m_pv = 1'b1;
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge and consumes the
  // expected acknowledge events.
  always @(negedge clk) begin
    if (!clr && p >= 0) begin
      bit exp_ack;
      chk("an", int'(an), int'(e_an));
      chk("seg", int'(seg), int'(e_seg));
      chk("dp", int'(dp), int'(e_dp));
      exp_ack = (ack_q.size() > 0) && (ack_q[0] == p);
      chk("load_ack", int'(load_ack), int'(exp_ack));
      if (exp_ack) void'(ack_q.pop_front());
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic z);
    value = v; dp_mask = m; lzb_en = z; load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic wait_mod(input int m);
    int guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while ((p % 160) != m && guard < 400);
    if (guard >= 400) begin
      tests++; fails++;
      $display("FAIL wait_mod(%0d) bound expired: got edge %0d, required position %0d", m, p, m);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int k;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_an", int'(an), 'hF);
    chk("reset_seg", int'(seg), 'h7F);
    chk("reset_dp", int'(dp), 1);
    chk("reset_ack", int'(load_ack), 0);
    @(negedge clk);
    clr = 1'b0;

    // Plain scan of zeros for 80 ticks
    wait_cycles(800);

    // Mid-frame load with a decimal point on digit 2
    wait_mod(60);
    do_load(16'h1A3F, 4'b0100, 1'b0);
    wait_cycles(400);

    // Leading-zero blanking
    wait_mod(30);
    do_load(16'h0050, 4'b0000, 1'b1);
    wait_cycles(350);

    // Two loads in one frame: only the last one is shown
    wait_mod(20);
    do_load(16'h1111, 4'b0001, 1'b0);
    wait_mod(60);
    do_load(16'h2222, 4'b0010, 1'b0);
    wait_cycles(400);

    // Load landing exactly on the boundary edge with nothing pending
    wait_mod(159);
    do_load(16'hBEEF, 4'b1001, 1'b0);
    wait_cycles(340);

    // Random loads, many with leading zeros
    for (int i = 0; i < 24; i++) begin
      v = 16'($urandom);
      k = $urandom_range(0, 4);
      v = (k == 4) ? 16'h0 : (v >> (4 * k));
      do_load(v, 4'($urandom), 1'($urandom_range(0, 1)));
      wait_cycles($urandom_range(1, 250));
    end
    wait_cycles(340);

    // Reset during DRIVE of digit 2 with a load pending
    wait_mod(95);
    do_load(16'h9999, 4'hF, 1'b0);
    #1;
    clr = 1'b1;
    #1;
    chk("midreset_an", int'(an), 'hF);
    chk("midreset_seg", int'(seg), 'h7F);
    chk("midreset_dp", int'(dp), 1);
    chk("midreset_ack", int'(load_ack), 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    clr = 1'b0;
    wait_cycles(400);

    chk("ack_queue_drained", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing controller for the 4-digit common-anode seven-segment display that shows square-root results. It generates its own scan tick and sequences each digit through a BLANK (ghost-suppression) phase and a DRIVE phase. It accepts new display values through a load/ack handshake and applies them only at frame boundaries, so a displayed frame never tears.

Parameters:
SRC_FREQ, 100000000, clk frequency in Hz
SCAN_FREQ, 1000, scan tick rate in Hz; tick period = SRC_FREQ/SCAN_FREQ cycles (integer division, minimum 1)
NUM_DIGITS, 4, number of digits; value width = 4*NUM_DIGITS
BLANK_TICKS, 1, ticks per digit with all anodes off (>=1)
DRIVE_TICKS, 3, ticks per digit with the anode on (>=1)

Ports:
clk  in  1  system clock
clr  in  1  asynchronous reset, active-high
value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 = rightmost
dp_mask  in  NUM_DIGITS  decimal-point enable per digit, 1 = lit
lzb_en  in  1  leading-zero blanking enable
load  in  1  one-cycle request to capture value/dp_mask
load_ack  out  1  one-cycle pulse when the pending value becomes active
an  out  NUM_DIGITS  anodes, active-low
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low

Behaviour:
- Reset (clr=1, async): an all 1, seg=7'h7F, dp=1, load_ack=0. Active and pending registers 0, pending_valid=0, state BLANK, digit index 0, tick counter 0, phase counter 0.
- Tick: free-running counter 0..SRC_FREQ/SCAN_FREQ-1. Tick is a one-cycle pulse in the cycle after the counter reaches its limit; the counter then wraps to 0.
- FSM per digit:
  - BLANK: lasts BLANK_TICKS ticks, then moves to DRIVE with the same digit.
  - DRIVE: lasts DRIVE_TICKS ticks, then moves to BLANK of digit+1.
  - Digit index wraps from NUM_DIGITS-1 to 0.
  - The phase counter resets at every state change.
- Frame boundary: the cycle of the DRIVE(NUM_DIGITS-1) -> BLANK(0) transition.
- Load handshake:
  - load=1 copies value/dp_mask/lzb_en into pending and sets pending_valid.
  - A second load before a frame boundary overwrites pending; only the last one is shown and only one ack is produced.
  - At a frame boundary with pending_valid=1: active <= pending, pending_valid <= 0, load_ack=1 for exactly that cycle.
  - If load and the frame boundary occur in the same cycle, the boundary commits the old pending (if any). The new load becomes pending and is applied at the next boundary.
- Outputs: all registered; they change one cycle after a state change.
  - BLANK: an all 1, seg=7'h7F, dp=1.
  - DRIVE digit i: an[i]=0, other anodes 1.
    - seg = decode(active nibble i).
    - dp = ~active_dp[i].
- Decode (active-low hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Leading-zero blanking, when active lzb=1: digit i (i>=1) is blanked if nibble i and all higher nibbles are 0.
  - Blanked digit: seg=7'h7F, anode still driven.
  - dp follows dp_mask regardless of blanking.
  - Digit 0 is never blanked.
- Ticks only advance the FSM; load/ack run every clk.
- Reset mid-frame: immediate return to reset state; any pending load is discarded with no ack.

Decomposition:
- Shared package (display_pkg):
  - seven-segment decode function/constant table
  - SEG_OFF = 7'h7F
  - state encoding {BLANK, DRIVE}
- Sub-module: the team's existing Clock_Enable generator, instantiated with src_freq=SRC_FREQ, target_freq=SCAN_FREQ, driving the tick.
- FSM, handshake and output registers stay in seg_scan_ctrl.

Test Plan:
All scenarios use SRC_FREQ=10, SCAN_FREQ=1 (tick every 10 cycles), NUM_DIGITS=4, BLANK_TICKS=1, DRIVE_TICKS=3.
1. Reset, then run 80 ticks -> anodes sequence: blank 1 tick, an=1110 for 3 ticks, blank, 1101 ... 0111, repeating every 16 ticks; seg=40 (digit "0") during every DRIVE.
2. load with value=16'h1A3F, dp_mask=4'b0100, lzb_en=0 mid-frame -> no change until the frame boundary; load_ack high for exactly 1 cycle; next frame shows seg F:0E, 3:30, A:08 with dp=0, 1:79.
3. value=16'h0050, lzb_en=1 -> digits 3 and 2 show seg=7F with the anode low; digit 1 shows 12; digit 0 shows 40.
4. Two loads (16'h1111 then 16'h2222) within one frame -> one load_ack; 2222 is displayed and 1111 never appears.
5. load in the exact frame-boundary cycle with no prior pending -> no ack at that boundary; ack and new value at the following boundary (16 ticks later).
6. Assert clr during DRIVE of digit 2 with a pending load -> an=1111, seg=7F, dp=1 immediately; after release, scanning restarts at digit 0 showing 0000 and no load_ack occurs.
